// File: rtl/packet_filter_pkg.sv
//==============================================================================
// Module   : packet_filter_pkg
// Purpose  : Shared state encoding, flit width and checksum helpers for the
//            Hermes packet injector and its downstream packet filter.
// Revision : 1.0
//==============================================================================
`default_nettype none

package packet_filter_pkg;

  localparam int c_FLIT_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    SIZE    = 3'd2,
    PAYLOAD = 3'd3,
    DRAIN   = 3'd4
  } pkt_state_e;

  function automatic logic [15:0] addr_checksum(input logic [15:0] addr,
                                                input logic [7:0]  xmax,
                                                input logic [7:0]  ymax);
    return addr ^ {xmax, ymax};
  endfunction

  function automatic logic [15:0] size_checksum(input logic [15:0] len,
                                                input logic [15:0] addr_chk);
    return len ^ addr_chk;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pi_out_stage.sv
//==============================================================================
// Module   : pi_out_stage
// Purpose  : Single-entry credit-handshaked output register; a held flit stays
//            stable until tx && credit_i, and may be reloaded in that cycle.
// Revision : 1.0
//==============================================================================
`default_nettype none

module pi_out_stage
  import packet_filter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [c_FLIT_W-1:0] data_i,
  input  logic                credit_i,
  output logic                tx_o,
  output logic [c_FLIT_W-1:0] data_o,
  output logic                free_o,
  output logic                xfer_o
);

  logic                tx_q;
  logic                tx_d;
  logic [c_FLIT_W-1:0] data_q;
  logic [c_FLIT_W-1:0] data_d;

  always_comb begin
    tx_d   = tx_q;
    data_d = data_q;
    if (load_i) begin
      tx_d   = 1'b1;
      data_d = data_i;
    end else if (tx_q && credit_i) begin
      tx_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q   <= 1'b0;
      data_q <= '0;
    end else begin
      tx_q   <= tx_d;
      data_q <= data_d;
    end
  end

  assign tx_o   = tx_q;
  assign data_o = data_q;
  assign free_o = !tx_q || credit_i;
  assign xfer_o = tx_q && credit_i;

endmodule

`default_nettype wire

// File: rtl/packet_injector.sv
//==============================================================================
// Module   : packet_injector
// Purpose  : Frames a request plus payload stream into a checksummed Hermes
//            packet (ADDR, SIZE, payload). Optional PACKET_INJECTOR_ERR_INJECT_EN
//            adds err_inj[1:0] to corrupt the ADDR/SIZE checksums.
// Revision : 1.0
//==============================================================================
`default_nettype none

module packet_injector
  import packet_filter_pkg::*;
#(
  parameter logic [7:0] XMax = 8'd3,
  parameter logic [7:0] YMax = 8'd3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [15:0]         req_addr,
  input  logic [15:0]         req_len,
  output logic                req_err,
  input  logic                pl_valid,
  input  logic [c_FLIT_W-1:0] pl_data,
  output logic                pl_ready,
  output logic                tx,
  output logic [c_FLIT_W-1:0] data_out,
  input  logic                credit_i,
`ifdef PACKET_INJECTOR_ERR_INJECT_EN
  input  logic [1:0]          err_inj,
`endif
  output logic                busy
);

  pkt_state_e state_q;
  pkt_state_e state_d;
  logic [15:0] addr_q;
  logic [15:0] addr_d;
  logic [15:0] len_q;
  logic [15:0] len_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        req_err_q;
  logic        req_err_d;

  logic                w_req_ok;
  logic                w_load;
  logic [c_FLIT_W-1:0] w_load_data;
  logic                w_free;
  logic                w_xfer;
  logic [1:0]          w_inj_new;
  logic [1:0]          w_inj_held;
  logic [15:0]         w_addr_chk_new;
  logic [15:0]         w_addr_chk_held;
  logic [15:0]         w_size_chk;
  logic [c_FLIT_W-1:0] w_addr_flit;
  logic [c_FLIT_W-1:0] w_size_flit;

`ifdef PACKET_INJECTOR_ERR_INJECT_EN
  logic [1:0] inj_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_q <= 2'b00;
    end else if (req_valid && req_ready) begin
      inj_q <= err_inj;
    end
  end

  // The ADDR flit is built in the accept cycle, so it uses the live bits.
  assign w_inj_new  = err_inj;
  assign w_inj_held = inj_q;
`else
  assign w_inj_new  = 2'b00;
  assign w_inj_held = 2'b00;
`endif

  assign w_req_ok = (req_len != 16'd0) && (req_addr[15:8] <= XMax) &&
                    (req_addr[7:0] <= YMax);

  // The SIZE checksum is keyed on the true address checksum, never the
  // corrupted one, so each injection bit disturbs exactly one flit.
  assign w_addr_chk_new  = addr_checksum(req_addr, XMax, YMax) ^ {15'd0, w_inj_new[0]};
  assign w_addr_chk_held = addr_checksum(addr_q, XMax, YMax);
  assign w_size_chk      = size_checksum(len_q, w_addr_chk_held) ^ {15'd0, w_inj_held[1]};
  assign w_addr_flit     = {w_addr_chk_new, req_addr};
  assign w_size_flit     = {w_size_chk, len_q};

  pi_out_stage u_out_stage (
    .clk      (clk),
    .reset    (reset),
    .load_i   (w_load),
    .data_i   (w_load_data),
    .credit_i (credit_i),
    .tx_o     (tx),
    .data_o   (data_out),
    .free_o   (w_free),
    .xfer_o   (w_xfer)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 16'd0;
      len_q     <= 16'd0;
      cnt_q     <= 16'd0;
      req_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      req_err_q <= req_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    req_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          len_d  = req_len;
          if (w_req_ok) begin
            state_d = ADDR;
          end else begin
            req_err_d = 1'b1;
          end
        end
      end
      // ADDR flit is already held; fall back to SIZE only if the link is stalled.
      ADDR: begin
        if (w_free) begin
          cnt_d   = len_q;
          state_d = PAYLOAD;
        end else begin
          state_d = SIZE;
        end
      end
      SIZE: begin
        if (w_free) begin
          cnt_d   = len_q;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pl_valid && w_free) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    pl_ready    = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && w_req_ok) begin
          w_load      = 1'b1;
          w_load_data = w_addr_flit;
        end
      end
      ADDR, SIZE: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_data = w_size_flit;
        end
      end
      PAYLOAD: begin
        pl_ready = w_free;
        if (pl_valid && w_free) begin
          w_load      = 1'b1;
          w_load_data = pl_data;
        end
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign req_err = req_err_q;

endmodule

`default_nettype wire

// File: tb/tb_packet_injector.sv
//==============================================================================
// Module   : tb_packet_injector
// Purpose  : Directed self-checking bench for packet_injector (XMax=YMax=3).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_packet_injector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'd0;
  logic [15:0] req_len = 16'd0;
  logic        req_err;
  logic        pl_valid = 1'b0;
  logic [31:0] pl_data = 32'd0;
  logic        pl_ready;
  logic        tx;
  logic [31:0] data_out;
  logic        credit_i = 1'b1;
  logic        busy;
`ifdef PACKET_INJECTOR_ERR_INJECT_EN
  logic [1:0]  err_inj = 2'b00;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  packet_injector dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_err   (req_err),
    .pl_valid  (pl_valid),
    .pl_data   (pl_data),
    .pl_ready  (pl_ready),
    .tx        (tx),
    .data_out  (data_out),
    .credit_i  (credit_i),
`ifdef PACKET_INJECTOR_ERR_INJECT_EN
    .err_inj   (err_inj),
`endif
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    cyc();
    chk("rst_tx", {31'd0, tx}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_err", {31'd0, req_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_plr", {31'd0, pl_ready}, 32'd0);
    nedge(); reset = 1'b0;
    cyc();
    chk("rst_rdy", {31'd0, req_ready}, 32'd1);

    // 1: back-to-back packet, full credit
    nedge(); req_valid = 1'b1; req_addr = 16'h0102; req_len = 16'd3;
    pl_valid = 1'b1; pl_data = 32'hA;
    cyc();
    chk("t1_addr", data_out, 32'h02010102);
    chk("t1_tx", {31'd0, tx}, 32'd1);
    chk("t1_plr_early", {31'd0, pl_ready}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_rdy_low", {31'd0, req_ready}, 32'd0);
    nedge(); req_valid = 1'b0;
    cyc();
    chk("t1_size", data_out, 32'h02020003);
    chk("t1_plr", {31'd0, pl_ready}, 32'd1);
    cyc();
    chk("t1_p0", data_out, 32'hA);
    nedge(); pl_data = 32'hB;
    cyc();
    chk("t1_p1", data_out, 32'hB);
    nedge(); pl_data = 32'hC;
    cyc();
    chk("t1_p2", data_out, 32'hC);
    chk("t1_drain_plr", {31'd0, pl_ready}, 32'd0);
    chk("t1_drain_rdy", {31'd0, req_ready}, 32'd0);
    nedge(); pl_valid = 1'b0;
    cyc();
    chk("t1_end_tx", {31'd0, tx}, 32'd0);
    chk("t1_end_rdy", {31'd0, req_ready}, 32'd1);
    chk("t1_end_busy", {31'd0, busy}, 32'd0);

    // 2: credit low for 4 cycles while SIZE is held
    nedge(); req_valid = 1'b1; pl_valid = 1'b1; pl_data = 32'hA;
    cyc();
    chk("t2_addr", data_out, 32'h02010102);
    nedge(); req_valid = 1'b0;
    cyc();
    chk("t2_size", data_out, 32'h02020003);
    nedge(); credit_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_hold_data", data_out, 32'h02020003);
      chk("t2_hold_plr", {31'd0, pl_ready}, 32'd0);
      chk("t2_hold_tx", {31'd0, tx}, 32'd1);
    end
    nedge(); credit_i = 1'b1;
    cyc();
    chk("t2_p0", data_out, 32'hA);
    nedge(); pl_data = 32'hB;
    cyc();
    chk("t2_p1", data_out, 32'hB);
    nedge(); pl_data = 32'hC;
    cyc();
    chk("t2_p2", data_out, 32'hC);
    nedge(); pl_valid = 1'b0;
    cyc();
    chk("t2_end_tx", {31'd0, tx}, 32'd0);
    chk("t2_end_rdy", {31'd0, req_ready}, 32'd1);

    // 3: rejected requests
    nedge(); req_valid = 1'b1; req_addr = 16'h0102; req_len = 16'd0;
    cyc();
    chk("t3_len0_err", {31'd0, req_err}, 32'd1);
    chk("t3_len0_tx", {31'd0, tx}, 32'd0);
    chk("t3_len0_busy", {31'd0, busy}, 32'd0);
    nedge(); req_valid = 1'b0;
    cyc();
    chk("t3_len0_pulse", {31'd0, req_err}, 32'd0);
    chk("t3_len0_tx2", {31'd0, tx}, 32'd0);
    nedge(); req_valid = 1'b1; req_addr = 16'h0400; req_len = 16'd3;
    cyc();
    chk("t3_x_err", {31'd0, req_err}, 32'd1);
    chk("t3_x_tx", {31'd0, tx}, 32'd0);
    chk("t3_x_busy", {31'd0, busy}, 32'd0);
    nedge(); req_valid = 1'b0;
    cyc();
    chk("t3_x_pulse", {31'd0, req_err}, 32'd0);
    nedge(); req_valid = 1'b1; req_addr = 16'h0304; req_len = 16'd3;
    cyc();
    chk("t3_y_err", {31'd0, req_err}, 32'd1);
    chk("t3_y_tx", {31'd0, tx}, 32'd0);
    nedge(); req_valid = 1'b0;
    cyc();

    // 4: payload stall of 3 cycles mid-packet
    nedge(); req_valid = 1'b1; req_addr = 16'h0102; req_len = 16'd3;
    pl_valid = 1'b1; pl_data = 32'hA;
    cyc();
    nedge(); req_valid = 1'b0;
    cyc();
    chk("t4_size", data_out, 32'h02020003);
    cyc();
    chk("t4_p0", data_out, 32'hA);
    nedge(); pl_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_bubble_tx", {31'd0, tx}, 32'd0);
      chk("t4_bubble_plr", {31'd0, pl_ready}, 32'd1);
      chk("t4_bubble_busy", {31'd0, busy}, 32'd1);
    end
    nedge(); pl_valid = 1'b1; pl_data = 32'hB;
    cyc();
    chk("t4_p1", data_out, 32'hB);
    chk("t4_p1_tx", {31'd0, tx}, 32'd1);
    nedge(); pl_data = 32'hC;
    cyc();
    chk("t4_p2", data_out, 32'hC);
    chk("t4_p2_plr", {31'd0, pl_ready}, 32'd0);
    nedge(); pl_valid = 1'b0;
    cyc();
    chk("t4_end_tx", {31'd0, tx}, 32'd0);
    chk("t4_end_rdy", {31'd0, req_ready}, 32'd1);

    // 5: asynchronous reset while payload is on the link
    nedge(); req_valid = 1'b1; pl_valid = 1'b1; pl_data = 32'hA;
    cyc();
    nedge(); req_valid = 1'b0;
    cyc();
    cyc();
    chk("t5_pre_tx", {31'd0, tx}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_tx", {31'd0, tx}, 32'd0);
    chk("t5_async_data", data_out, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    nedge(); reset = 1'b0; pl_valid = 1'b0;
    nedge(); req_valid = 1'b1; req_len = 16'd1; pl_valid = 1'b1; pl_data = 32'hD;
    cyc();
    chk("t5_addr", data_out, 32'h02010102);
    nedge(); req_valid = 1'b0;
    cyc();
    chk("t5_size", data_out, 32'h02000001);
    cyc();
    chk("t5_p0", data_out, 32'hD);
    chk("t5_drain_rdy", {31'd0, req_ready}, 32'd0);
    nedge(); pl_valid = 1'b0;
    cyc();
    chk("t5_end_tx", {31'd0, tx}, 32'd0);
    chk("t5_end_rdy", {31'd0, req_ready}, 32'd1);

`ifdef PACKET_INJECTOR_ERR_INJECT_EN
    // 6: ADDR checksum corruption only
    nedge(); req_valid = 1'b1; req_addr = 16'h0102; req_len = 16'd3;
    err_inj = 2'b01; pl_valid = 1'b1; pl_data = 32'hA;
    cyc();
    chk("t6_addr_inj", data_out, 32'h02000102);
    nedge(); req_valid = 1'b0; err_inj = 2'b00;
    cyc();
    chk("t6_size_clean", data_out, 32'h02020003);
    cyc();
    nedge(); pl_data = 32'hB;
    cyc();
    nedge(); pl_data = 32'hC;
    cyc();
    chk("t6_p2", data_out, 32'hC);
    nedge(); pl_valid = 1'b0;
    cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
